// File: rtl/shift_serializer_pkg.sv
// Shared definitions for the multi-lane serializer: bit-order encodings, FSM states
// and a constant clog2 used to size the length/bit counter.
package shift_serializer_pkg;

  localparam bit ORDER_LSB_FIRST = 1'b0;
  localparam bit ORDER_MSB_FIRST = 1'b1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ser_lane.sv
// One serial lane: WIDTH-bit load/shift register, zero-filled from the side opposite
// the output bit. Load has priority over shift.
module ser_lane
  import shift_serializer_pkg::*;
#(
  parameter int WIDTH     = 20,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             dout
);

  logic [WIDTH-1:0] sreg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sreg <= '0;
    end else if (load) begin
      sreg <= din;
    end else if (shift) begin
      if (MSB_FIRST == ORDER_MSB_FIRST) sreg <= {sreg[WIDTH-2:0], 1'b0};
      else                              sreg <= {1'b0, sreg[WIDTH-1:1]};
    end
  end

  assign dout = (MSB_FIRST == ORDER_MSB_FIRST) ? sreg[WIDTH-1] : sreg[0];

endmodule

// File: rtl/shift_serializer.sv
// Multi-lane parallel-to-serial converter with a one-word holding buffer for gap-free
// back-to-back frames; FSM, bit counter, handshake and done pulse live here.
module shift_serializer
  import shift_serializer_pkg::*;
#(
  parameter int WIDTH      = 20,
  parameter int LANES      = 1,
  parameter bit MSB_FIRST  = 1'b0,
  parameter bit IDLE_LEVEL = 1'b0,
  parameter int CNT_W      = clog2(WIDTH + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   shift_en,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] in_data,
  input  logic [CNT_W-1:0]       in_len,
  output logic [LANES-1:0]       sout,
  output logic                   frame,
  output logic                   busy,
  output logic                   done
);

  localparam logic [CNT_W-1:0] WIDTH_C = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  state_t                 state, state_n;
  logic [CNT_W-1:0]       cnt;
  logic                   hold_full;
  logic [LANES*WIDTH-1:0] hold_data;
  logic [CNT_W-1:0]       hold_len;
  logic [CNT_W-1:0]       len_clamped;
  logic                   accept, transfer, shift, done_n;
  logic [LANES-1:0]       lane_bit;

  assign in_ready    = !hold_full;
  assign accept      = in_valid && !hold_full;
  assign len_clamped = (in_len == '0 || in_len > WIDTH_C) ? WIDTH_C : in_len;

  always_comb begin
    state_n  = state;
    transfer = 1'b0;
    shift    = 1'b0;
    done_n   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (hold_full) begin
          transfer = 1'b1;
          state_n  = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (shift_en) begin
          if (cnt != '0) begin
            shift = 1'b1;
          end else if (hold_full) begin
            // Reload straight from the holding buffer: no idle cycle between frames.
            transfer = 1'b1;
          end else begin
            state_n = ST_IDLE;
            done_n  = 1'b1;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      hold_full <= 1'b0;
      hold_data <= '0;
      hold_len  <= '0;
      done      <= 1'b0;
    end else begin
      state <= state_n;
      done  <= done_n;
      if (accept) begin
        hold_full <= 1'b1;
        hold_data <= in_data;
        hold_len  <= len_clamped;
      end else if (transfer) begin
        hold_full <= 1'b0;
      end
      if (transfer)   cnt <= hold_len - ONE_C;
      else if (shift) cnt <= cnt - ONE_C;
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    ser_lane #(
      .WIDTH    (WIDTH),
      .MSB_FIRST(MSB_FIRST)
    ) u_lane (
      .clk  (clk),
      .reset(reset),
      .load (transfer),
      .shift(shift),
      .din  (hold_data[k*WIDTH +: WIDTH]),
      .dout (lane_bit[k])
    );
  end

  assign frame = (state == ST_SHIFT);
  assign busy  = frame || hold_full;
  assign sout  = frame ? lane_bit : {LANES{IDLE_LEVEL}};

endmodule

// File: tb/tb_shift_serializer.sv
// Two serializers (2-lane LSB-first idle-0, 1-lane MSB-first idle-1) on shared controls,
// checked cycle by cycle against a frame-level reference model with a word queue.
module tb_shift_serializer;

  typedef struct {
    logic [19:0] d0;
    logic [19:0] d1;
    logic [19:0] dm;
    int          len;
  } frm_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        shift_en;
  logic        in_valid;
  logic [4:0]  in_len;
  logic [39:0] in_data0;
  logic [19:0] in_data1;
  logic        in_ready0, in_ready1;
  logic [1:0]  sout0;
  logic [0:0]  sout1;
  logic        frame0, frame1, busy0, busy1, done0, done1;

  int total = 0;
  int bad   = 0;
  int se_mode = 1;
  int se_cnt  = 0;

  frm_t hq[$];
  frm_t cur;
  bit   m_active = 1'b0;
  int   m_idx = 0;
  bit   m_done = 1'b0;

  always #5 clk = ~clk;

  shift_serializer #(.WIDTH(20), .LANES(2), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut0 (
    .clk(clk), .reset(reset), .shift_en(shift_en), .in_valid(in_valid), .in_ready(in_ready0),
    .in_data(in_data0), .in_len(in_len), .sout(sout0), .frame(frame0), .busy(busy0), .done(done0)
  );

  shift_serializer #(.WIDTH(20), .LANES(1), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) dut1 (
    .clk(clk), .reset(reset), .shift_en(shift_en), .in_valid(in_valid), .in_ready(in_ready1),
    .in_data(in_data1), .in_len(in_len), .sout(sout1), .frame(frame1), .busy(busy1), .done(done1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int clamp_len(input int l);
    return (l == 0 || l > 20) ? 20 : l;
  endfunction

  // Bit-rate tick: 1 = every clk, 3 = every third clk, 0 = random.
  initial begin
    shift_en = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      se_cnt++;
      case (se_mode)
        1:       shift_en = 1'b1;
        3:       shift_en = (se_cnt % 3 == 0);
        default: shift_en = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: compare outputs with the model state, then advance the model across the next edge.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        hq.delete();
        m_active = 1'b0;
        m_idx    = 0;
        m_done   = 1'b0;
      end else begin
        chk("frame0", frame0, m_active);
        chk("frame1", frame1, m_active);
        chk("sout0", sout0, m_active ? {cur.d1[m_idx], cur.d0[m_idx]} : 2'b00);
        chk("sout1", sout1, m_active ? cur.dm[19 - m_idx] : 1'b1);
        chk("done0", done0, m_done);
        chk("done1", done1, m_done);
        chk("in_ready0", in_ready0, hq.size() == 0);
        chk("in_ready1", in_ready1, hq.size() == 0);
        chk("busy0", busy0, m_active || hq.size() != 0);
        chk("busy1", busy1, m_active || hq.size() != 0);
        m_done = 1'b0;
        if (m_active) begin
          if (shift_en) begin
            if (m_idx == cur.len - 1) begin
              if (hq.size() != 0) begin
                cur   = hq.pop_front();
                m_idx = 0;
              end else begin
                m_active = 1'b0;
                m_done   = 1'b1;
              end
            end else begin
              m_idx++;
            end
          end
        end else if (hq.size() != 0) begin
          cur      = hq.pop_front();
          m_active = 1'b1;
          m_idx    = 0;
        end
      end
    end
  end

  task automatic send(input logic [19:0] d0, input logic [19:0] d1, input logic [19:0] dm,
                      input int len);
    frm_t f;
    bit   acc;
    f.d0 = d0; f.d1 = d1; f.dm = dm; f.len = clamp_len(len);
    in_valid = 1'b1;
    in_data0 = {d1, d0};
    in_data1 = dm;
    in_len   = 5'(len);
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      acc = in_ready0;
      @(posedge clk);
      #1;
      if (acc) begin
        hq.push_back(f);
        in_valid = 1'b0;
        in_data0 = {$urandom(), $urandom()};
        in_data1 = 20'($urandom());
        return;
      end
    end
    in_valid = 1'b0;
    total++; bad++;
    $display("FAIL send_timeout: word not accepted within 500 clk");
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      if (!m_active && hq.size() == 0 && !m_done) return;
    end
    total++; bad++;
    $display("FAIL idle_timeout: frames still pending after 3000 clk");
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_len = '0; in_data0 = '0; in_data1 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sout0", sout0, 2'b00);
    chk("rst_sout1", sout1, 1'b1);
    chk("rst_ready", in_ready0, 1'b1);
    chk("rst_busy", busy0, 1'b0);
    reset = 1'b0;

    se_mode = 1;
    send(20'h0000B, 20'h00000, 20'h0000B, 0);          // full 20-bit frame
    wait_idle();
    send(20'h00000, 20'h00000, 20'hA0000, 4);          // MSB lane sends 1,0,1,0
    wait_idle();
    send(20'h12345, 20'h6789A, 20'hBCDEF, 8);          // back-to-back pair
    send(20'h0F0F0, 20'h33333, 20'h55555, 6);
    wait_idle();

    se_mode = 3;
    send(20'h00001, 20'h00002, 20'h80001, 0);
    wait_idle();

    se_mode = 1;
    send(20'hFFFFF, 20'hABCDE, 20'h13579, 25);
    wait_idle();
    send(20'h00001, 20'h00001, 20'h80000, 1);
    wait_idle();

    // Reset mid-frame at bit 7 with the holding buffer occupied.
    send(20'hFFFFF, 20'hFFFFF, 20'hFFFFF, 20);
    send(20'h55555, 20'hAAAAA, 20'h55555, 20);
    for (int i = 0; i < 100; i++) begin
      if (m_active && m_idx == 7 && hq.size() == 1) break;
      @(posedge clk);
      #1;
    end
    chk("pre_rst_busy", busy0, 1'b1);
    reset = 1'b1;
    #1;
    chk("arst_sout0", sout0, 2'b00);
    chk("arst_sout1", sout1, 1'b1);
    chk("arst_frame", frame0, 1'b0);
    chk("arst_busy", busy0, 1'b0);
    chk("arst_ready", in_ready0, 1'b1);
    chk("arst_done", done0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    wait_idle();

    se_mode = 0;
    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      send(20'($urandom()), 20'($urandom()), 20'($urandom()), $urandom_range(0, 31));
      if ($urandom_range(0, 7) == 0) wait_idle();
    end
    wait_idle();
    repeat (3) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
